// File: rtl/posit_accum_result_buffer_if.sv
// ---------------------------------------------------------------------------
// posit_accum_result_buffer_if
//   Bundles the accumulator-side, downstream-side and status signals of the
//   posit accumulator result buffer.
//
//   Accumulator side : acc_start, acc_result, acc_inf, acc_zero, acc_done
//   Flow control     : credit_ok (upstream may issue acc_start this cycle)
//   Downstream side  : out_valid / out_ready handshake, out_data, out_inf,
//                      out_zero, out_seq (head entry, first-word-fall-through)
//   Status           : level (occupancy), err_overflow, err_credit (sticky)
//
//   slave  : the buffer itself
//   master : the environment (accumulator + downstream consumer)
// ---------------------------------------------------------------------------
interface posit_accum_result_buffer_if #(
    parameter int NBITS = 32,
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH + 1);

    logic             acc_start;
    logic [NBITS-1:0] acc_result;
    logic             acc_inf;
    logic             acc_zero;
    logic             acc_done;
    logic             credit_ok;
    logic             out_valid;
    logic             out_ready;
    logic [NBITS-1:0] out_data;
    logic             out_inf;
    logic             out_zero;
    logic [15:0]      out_seq;
    logic [LW-1:0]    level;
    logic             err_overflow;
    logic             err_credit;

    modport slave (
        input  acc_start, acc_result, acc_inf, acc_zero, acc_done, out_ready,
        output credit_ok, out_valid, out_data, out_inf, out_zero, out_seq,
               level, err_overflow, err_credit
    );

    modport master (
        output acc_start, acc_result, acc_inf, acc_zero, acc_done, out_ready,
        input  credit_ok, out_valid, out_data, out_inf, out_zero, out_seq,
               level, err_overflow, err_credit
    );
endinterface

// File: rtl/posit_accum_result_buffer.sv
// ---------------------------------------------------------------------------
// posit_accum_result_buffer
//   Captures results of a fixed-latency posit accumulator into a
//   first-word-fall-through FIFO, tags each with a 16-bit sequence number,
//   and issues credits so upstream never has more operations outstanding
//   than the FIFO can absorb.
//
//   Parameters
//     NBITS : posit width
//     DEPTH : FIFO entries (power of 2, 2..64)
//     LAT   : accumulator start-to-done latency (1..15)
//
//   Ports
//     clk   : sole clock, rising edge
//     reset : synchronous, active-high
//     bus   : posit_accum_result_buffer_if.slave (see interface header)
// ---------------------------------------------------------------------------
module posit_accum_result_buffer #(
    parameter int NBITS = 32,
    parameter int DEPTH = 8,
    parameter int LAT   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    posit_accum_result_buffer_if.slave     bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int SW = LW + 5;   // room for level + 4-bit inflight

    typedef struct packed {
        logic [NBITS-1:0] data;
        logic             inf;
        logic             zero;
        logic [15:0]      seq;
    } entry_t;

    // ---------------- state ----------------
    entry_t         mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [LW-1:0]  level_q,    level_d;
    logic [3:0]     inflight_q, inflight_d;
    logic [15:0]    seq_q,      seq_d;
    logic [3:0]     drain_q,    drain_d;
    logic           err_ovf_q,  err_ovf_d;
    logic           err_cr_q,   err_cr_d;

    // ---------------- decode ----------------
    logic           in_window;
    logic           done_ok;
    logic           done_orphan;
    logic           full;
    logic           not_empty;
    logic           do_pop;
    logic           do_push;
    logic           drop;
    logic           credit;
    logic [SW-1:0]  occupancy;
    entry_t         push_entry;
    entry_t         head;

    // NOTE: combinational blocks use blocking '=' so later lines see earlier
    // results within the same evaluation; clocked blocks use '<=' only.
    always_comb begin
        // Results still draining from before a reset are ignored silently.
        in_window   = (drain_q != 4'd0);
        done_ok     = bus.acc_done && !in_window && (inflight_q != 4'd0);
        done_orphan = bus.acc_done && !in_window && (inflight_q == 4'd0);

        not_empty = (level_q != '0);
        full      = (level_q == LW'(DEPTH));
        do_pop    = not_empty && bus.out_ready;
        // A full FIFO still accepts when the head leaves in the same cycle.
        do_push   = done_ok && (!full || do_pop);
        drop      = done_ok && full && !do_pop;

        occupancy = SW'(level_q) + SW'(inflight_q);
        credit    = (occupancy < SW'(DEPTH));

        push_entry.data = bus.acc_result;
        push_entry.inf  = bus.acc_inf;
        push_entry.zero = bus.acc_zero;
        push_entry.seq  = seq_q;
    end

    // NOTE: every _d signal gets its hold value first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        inflight_d = inflight_q;
        seq_d      = seq_q;
        drain_d    = drain_q;
        err_ovf_d  = err_ovf_q;
        err_cr_d   = err_cr_q;

        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);

        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // Saturate upward so a runaway upstream cannot wrap the count to 0.
        unique case ({bus.acc_start, done_ok})
            2'b10:   if (inflight_q != 4'hF) inflight_d = inflight_q + 4'd1;
            2'b01:   inflight_d = inflight_q - 4'd1;
            default: inflight_d = inflight_q;
        endcase

        // Dropped pushes still consume a sequence number so the gap is visible.
        if (done_ok) seq_d = seq_q + 16'd1;

        if (in_window) drain_d = drain_q - 4'd1;

        if (drop) err_ovf_d = 1'b1;
        if (done_orphan || (bus.acc_start && !credit)) err_cr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            inflight_q <= '0;
            seq_q      <= '0;
            drain_q    <= 4'(LAT);
            err_ovf_q  <= 1'b0;
            err_cr_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            inflight_q <= inflight_d;
            seq_q      <= seq_d;
            drain_q    <= drain_d;
            err_ovf_q  <= err_ovf_d;
            err_cr_q   <= err_cr_d;
        end
    end

    // NOTE: the storage array has no reset; its contents are only observable
    // through the head mux below, which is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push && !reset) mem_q[wr_ptr_q] <= push_entry;
    end

    // ---------------- outputs ----------------
    always_comb begin
        head = not_empty ? mem_q[rd_ptr_q] : '0;
    end

    assign bus.credit_ok    = credit;
    assign bus.out_valid    = not_empty;
    assign bus.out_data     = head.data;
    assign bus.out_inf      = head.inf;
    assign bus.out_zero     = head.zero;
    assign bus.out_seq      = head.seq;
    assign bus.level        = level_q;
    assign bus.err_overflow = err_ovf_q;
    assign bus.err_credit   = err_cr_q;

endmodule

// File: tb/tb_posit_accum_result_buffer.sv
// ---------------------------------------------------------------------------
// tb_posit_accum_result_buffer
//   Directed scenarios for the posit accumulator result buffer. A small
//   fixed-latency accumulator stand-in schedules acc_done LAT cycles after
//   each acc_start; expected FIFO entries are queued when the done is driven
//   and a negedge monitor pops and compares them on every handshake.
// ---------------------------------------------------------------------------
module tb_posit_accum_result_buffer;
    localparam int NBITS = 32;
    localparam int DEPTH = 8;
    localparam int LAT   = 4;

    typedef struct packed {
        logic [31:0] d;
        logic        inf;
        logic        zero;
        logic        counted;  // done is expected to be accepted (not discarded)
        logic        stored;   // accepted done is expected to land in the FIFO
    } op_t;

    typedef struct packed {
        logic [31:0] d;
        logic        inf;
        logic        zero;
        logic [15:0] seq;
    } exp_t;

    localparam op_t NOP = '0;

    logic clk;
    logic reset;

    posit_accum_result_buffer_if #(.NBITS(NBITS), .DEPTH(DEPTH)) bus ();

    posit_accum_result_buffer #(.NBITS(NBITS), .DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    op_t         sched [int];
    exp_t        sb [$];
    int          cyc;
    logic [15:0] exp_seq;
    int          n_tests;
    int          n_fail;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic op_t mk(input logic [31:0] d, input logic inf = 1'b0,
                               input logic zero = 1'b0, input logic counted = 1'b1,
                               input logic stored = 1'b1);
        op_t o;
        o.d = d; o.inf = inf; o.zero = zero; o.counted = counted; o.stored = stored;
        return o;
    endfunction

    // Drive one cycle of inputs, then advance to just after the next rising edge.
    task automatic step(input logic start, input op_t op, input logic ready,
                        input logic rst = 1'b0);
        op_t o;
        bus.acc_start = start;
        bus.out_ready = ready;
        reset         = rst;
        if (start) sched[cyc + LAT] = op;
        if (sched.exists(cyc)) begin
            o = sched[cyc];
            sched.delete(cyc);
            bus.acc_done   = 1'b1;
            bus.acc_result = o.d;
            bus.acc_inf    = o.inf;
            bus.acc_zero   = o.zero;
            if (o.counted) begin
                if (o.stored) sb.push_back({o.d, o.inf, o.zero, exp_seq});
                exp_seq++;
            end
        end else begin
            bus.acc_done   = 1'b0;
            bus.acc_result = '0;
            bus.acc_inf    = 1'b0;
            bus.acc_zero   = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input logic ready);
        for (int i = 0; i < n; i++) step(1'b0, NOP, ready);
    endtask

    // Two reset cycles (reset values checked while reset is still high),
    // then LAT idle cycles so the drain window has closed.
    task automatic do_reset();
        sched.delete();
        step(1'b0, NOP, 1'b0, 1'b1);
        sb.delete();
        exp_seq = '0;
        check("rst_out_valid", 64'(bus.out_valid),    64'd0);
        check("rst_level",     64'(bus.level),        64'd0);
        check("rst_credit_ok", 64'(bus.credit_ok),    64'd1);
        check("rst_err_ovf",   64'(bus.err_overflow), 64'd0);
        check("rst_err_cr",    64'(bus.err_credit),   64'd0);
        check("rst_out_data",  64'(bus.out_data),     64'd0);
        check("rst_out_flags", 64'({bus.out_inf, bus.out_zero}), 64'd0);
        check("rst_out_seq",   64'(bus.out_seq),      64'd0);
        step(1'b0, NOP, 1'b0, 1'b1);
        check("rst_credit_after", 64'(bus.credit_ok), 64'd1);
        idle(LAT, 1'b0);
    endtask

    // Scoreboard monitor: compares the head entry on every accepted handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL pop_unexpected: got seq 0x%0h data 0x%0h required no entry",
                             bus.out_seq, bus.out_data);
                end else begin
                    e = sb.pop_front();
                    check("pop_entry",
                          64'({bus.out_data, bus.out_inf, bus.out_zero, bus.out_seq}),
                          64'(e));
                end
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        exp_seq = '0;
        reset   = 1'b1;
        bus.acc_start  = 1'b0;
        bus.acc_done   = 1'b0;
        bus.acc_result = '0;
        bus.acc_inf    = 1'b0;
        bus.acc_zero   = 1'b0;
        bus.out_ready  = 1'b0;

        // ---- single operation: latency and first-word-fall-through ----
        do_reset();
        step(1'b1, mk(32'h4000_0000), 1'b1);       // cycle T
        idle(LAT, 1'b1);                            // done driven at T+4
        check("s1_out_valid", 64'(bus.out_valid), 64'd1);   // T+5
        check("s1_out_data",  64'(bus.out_data),  64'h4000_0000);
        check("s1_out_seq",   64'(bus.out_seq),   64'd0);
        idle(1, 1'b1);
        check("s1_level_after_pop", 64'(bus.level), 64'd0); // T+6
        check("s1_sb_empty", 64'(sb.size()), 64'd0);

        // ---- fill to DEPTH with back-to-back starts, then drain ----
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, mk(32'h1000_0000 + 32'(i)), 1'b0);
            check("s2_credit_ok", 64'(bus.credit_ok), (i < DEPTH - 1) ? 64'd1 : 64'd0);
        end
        idle(LAT, 1'b0);
        check("s2_level_full", 64'(bus.level),     64'd8);
        check("s2_credit_full", 64'(bus.credit_ok), 64'd0);
        check("s2_errs", 64'({bus.err_overflow, bus.err_credit}), 64'd0);
        idle(DEPTH, 1'b1);
        check("s2_level_drained", 64'(bus.level), 64'd0);
        check("s2_credit_drained", 64'(bus.credit_ok), 64'd1);
        check("s2_sb_empty", 64'(sb.size()), 64'd0);

        // ---- push+pop at full, overflow drop, credit violation ----
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, mk(32'h2000_0000 + 32'(i)), 1'b0);
        step(1'b1, mk(32'h2000_0008), 1'b0);                    // start with credit_ok=0
        check("s3_err_credit_set", 64'(bus.err_credit), 64'd1);
        step(1'b1, mk(32'h2000_0009, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0); // will be dropped
        idle(2, 1'b0);
        check("s3_level_full", 64'(bus.level), 64'd8);
        step(1'b0, NOP, 1'b1);                                  // done + pop together
        check("s3_level_push_pop", 64'(bus.level), 64'd8);
        check("s3_no_overflow",    64'(bus.err_overflow), 64'd0);
        step(1'b0, NOP, 1'b0);                                  // done at full, no pop
        check("s3_level_drop", 64'(bus.level), 64'd8);
        check("s3_overflow",   64'(bus.err_overflow), 64'd1);
        idle(DEPTH, 1'b1);
        check("s3_level_drained", 64'(bus.level), 64'd0);
        step(1'b1, mk(32'h2000_000A), 1'b1);                    // expected seq 10
        idle(LAT + 1, 1'b1);
        check("s3_err_credit_sticky", 64'(bus.err_credit),   64'd1);
        check("s3_err_ovf_sticky",    64'(bus.err_overflow), 64'd1);
        check("s3_sb_empty", 64'(sb.size()), 64'd0);

        // ---- reset with operations in flight, then an orphan done ----
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, mk(32'h3000_0000, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        step(1'b0, NOP, 1'b1, 1'b1);                            // one-cycle reset
        idle(LAT, 1'b1);                                        // dones land in window
        check("s4_level", 64'(bus.level), 64'd0);
        check("s4_errs",  64'({bus.err_overflow, bus.err_credit}), 64'd0);
        check("s4_out_valid", 64'(bus.out_valid), 64'd0);
        sched[cyc] = mk(32'h3000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, NOP, 1'b1);
        check("s4_orphan_err_credit", 64'(bus.err_credit), 64'd1);
        check("s4_orphan_level", 64'(bus.level), 64'd0);

        // ---- NaR and zero carried unchanged; reset discards stored entries ----
        do_reset();
        step(1'b1, mk(32'h8000_0000, 1'b1, 1'b0), 1'b0);
        step(1'b1, mk(32'h0000_0000, 1'b0, 1'b1), 1'b0);
        idle(LAT - 1, 1'b0);
        check("s5_level1",   64'(bus.level),    64'd1);
        check("s5_nar_data", 64'(bus.out_data), 64'h8000_0000);
        check("s5_nar_flags", 64'({bus.out_inf, bus.out_zero}), 64'b10);
        idle(1, 1'b0);
        check("s5_level2", 64'(bus.level), 64'd2);
        idle(1, 1'b1);                                          // pop NaR
        check("s5_zero_flags", 64'({bus.out_inf, bus.out_zero}), 64'b01);
        check("s5_zero_seq",   64'(bus.out_seq), 64'd1);
        idle(1, 1'b1);                                          // pop zero
        check("s5_sb_empty", 64'(sb.size()), 64'd0);
        step(1'b1, mk(32'h5555_AAAA), 1'b0);
        idle(LAT, 1'b0);
        check("s5_stored_before_reset", 64'(bus.level), 64'd1);
        do_reset();                                             // entry discarded
        idle(2, 1'b1);
        check("s5_level_after_reset", 64'(bus.level), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/posit_accum_result_buffer.md
POSIT_ACCUM_RESULT_BUFFER -- requirements
Module: posit_accum_result_buffer

Interface
REQ-001 Parameters SHALL be: NBITS, default 32, posit width; DEPTH, default 8, FIFO entries (power of 2, 2..64); LAT, default 4, start-to-done latency of the accumulator pipeline (1..15).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 acc_start  input  1  copy of the start strobe driven into the accumulator; one operation issued per high cycle.
REQ-005 acc_result  input  NBITS  accumulator result posit; qualified by acc_done.
REQ-006 acc_inf / acc_zero  input  1 each  accumulator NaR / zero flags; qualified by acc_done.
REQ-007 acc_done  input  1  accumulator result-valid strobe.
REQ-008 credit_ok  output  1  upstream may assert acc_start this cycle.
REQ-009 out_valid / out_ready  output / input  1 each  downstream valid/ready handshake.
REQ-010 out_data  output  NBITS  head-entry posit.
REQ-011 out_inf / out_zero  output  1 each  head-entry flags.
REQ-012 out_seq  output  16  head-entry sequence number.
REQ-013 level  output  clog2(DEPTH+1)  current FIFO occupancy.
REQ-014 err_overflow / err_credit  output  1 each  sticky error flags.

Function
REQ-015 Push: when acc_done=1 and not discarded (REQ-024), {acc_result, acc_inf, acc_zero, seq_cnt} SHALL be written at the tail.
REQ-016 seq_cnt SHALL be a 16-bit counter incremented on every non-discarded acc_done, including dropped pushes, wrapping 0xFFFF->0x0000.
REQ-017 Pop: an entry SHALL be removed when out_valid=1 and out_ready=1.
REQ-018 Output SHALL be first-word-fall-through: out_valid=1 whenever level>0; out_data/out_inf/out_zero/out_seq show the head entry; push-to-out_valid latency is 1 cycle when empty.
REQ-019 Order SHALL be strict FIFO; read/write pointers wrap modulo DEPTH.
REQ-020 Simultaneous push and pop SHALL leave level unchanged, at every level including full and empty (when empty, pop cannot occur, so level becomes 1).
REQ-021 Push while level==DEPTH and no pop in that cycle SHALL drop the result, leave the FIFO unchanged, and set err_overflow.
REQ-022 inflight counter (4 bits): +1 on acc_start, -1 on non-discarded acc_done, unchanged when both occur; never decremented below 0.
REQ-023 credit_ok SHALL equal (level + inflight) < DEPTH, computed from registered state only.
REQ-024 Drain window: for LAT cycles after reset deasserts, acc_done SHALL be discarded silently (no push, no seq/inflight/error change); outside the window, acc_done with inflight==0 SHALL be discarded and set err_credit.
REQ-025 acc_start while credit_ok==0 SHALL set err_credit; the start is still counted in inflight.
REQ-026 No data transformation: out_data SHALL be bit-identical to the captured acc_result; NaR (MSB 1, rest 0) is carried unchanged with its flag.

Reset
REQ-027 While reset=1: pointers, level, inflight, seq_cnt = 0; err_overflow = err_credit = 0; out_valid = 0; out_data, out_inf, out_zero, out_seq = 0; drain-window counter loaded to LAT.
REQ-028 During and immediately after reset, credit_ok SHALL be 1.
REQ-029 Reset mid-operation SHALL discard all stored entries; in-flight results covered by REQ-024.
REQ-030 Error flags SHALL clear only on reset.

Verification
REQ-031 After reset + LAT idle cycles, acc_start at cycle T, acc_done at T+4 with acc_result=0x40000000, out_ready=1 -> out_valid=1 at T+5, out_data=0x40000000, out_seq=0, level=0 at T+6.
REQ-032 out_ready=0, 8 back-to-back acc_start with dones 4 cycles later -> credit_ok=0 from the cycle after the 8th start, level=8, then drain with out_ready=1 yields out_seq 0..7 in order, no errors.
REQ-033 level=8, acc_done with out_ready=1 in the same cycle -> accepted, level stays 8, err_overflow=0; later acc_done at level=8 with out_ready=0 -> dropped, err_overflow=1, next stored out_seq skips one value.
REQ-034 acc_start while credit_ok=0 -> err_credit=1 next cycle, remains 1 until reset.
REQ-035 3 operations in flight, reset for 1 cycle -> dones arriving within LAT cycles discarded, no error, level=0; an acc_done after the window with no start -> err_credit=1.
REQ-036 acc_done with acc_result=0x80000000, acc_inf=1 -> out_data=0x80000000, out_inf=1, out_zero=0.
